// File: rtl/sound_vol_env.sv
// Volume envelope generator for one pulse/noise channel (NRx2 semantics).
// Optional macro VOL_ENV_PRESCALE_EN: divide the 512 Hz frame-sequencer pulse by 8 internally.
module sound_vol_env #(
   parameter int PERIOD_W = 3,
   parameter int VOL_W    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                env_tick,
   input  logic                trigger,
   input  logic [VOL_W-1:0]    init_vol,
   input  logic                env_dir,
   input  logic [PERIOD_W-1:0] env_period,
   output logic [VOL_W-1:0]    target_vol,
   output logic                dac_enable,
   output logic                env_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

   localparam int CNT_W = PERIOD_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {PERIOD_W{1'b0}}};
   localparam logic [VOL_W-1:0] VOL_MAX  = '1;
   localparam logic [VOL_W-1:0] VOL_ONE  = {{(VOL_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t              r_state;
   logic [VOL_W-1:0]    r_vol;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_dir;
   logic [PERIOD_W-1:0] r_per;
   logic                r_dac_en;
   logic                w_tick;
   logic                w_trig_hold;
   logic [VOL_W-1:0]    w_vol_step;
   logic                w_at_lim;

`ifdef VOL_ENV_PRESCALE_EN
   logic [2:0] r_presc;

   // Free-running divide-by-8 of env_tick; only rst_n clears it, so phase survives triggers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_presc <= 3'd0;
      else if (env_tick) r_presc <= r_presc + 3'd1;
   end

   assign w_tick = env_tick && (r_presc == 3'd7);
`else
   assign w_tick = env_tick;
`endif

   assign w_trig_hold = (env_period == '0) ||
                        ( env_dir && (init_vol == VOL_MAX)) ||
                        (!env_dir && (init_vol == '0));
   assign w_vol_step  = r_dir ? (r_vol + VOL_ONE) : (r_vol - VOL_ONE);
   assign w_at_lim    = r_dir ? (w_vol_step == VOL_MAX) : (w_vol_step == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_vol    <= '0;
         r_cnt    <= '0;
         r_dir    <= 1'b0;
         r_per    <= '0;
         r_dac_en <= 1'b0;
      end else begin
         r_dac_en <= (init_vol != '0) || env_dir;
         if (!r_dac_en) begin
            r_state <= ST_IDLE;
            r_vol   <= '0;
         end else if (trigger) begin
            // Trigger fully restarts and takes priority over a coincident tick.
            r_vol   <= init_vol;
            r_dir   <= env_dir;
            r_per   <= env_period;
            r_cnt   <= (env_period == '0) ? CNT_FULL : {1'b0, env_period};
            r_state <= w_trig_hold ? ST_HOLD : ST_RUN;
         end else if (w_tick && (r_state == ST_RUN)) begin
            if (r_cnt > CNT_ONE) begin
               r_cnt <= r_cnt - CNT_ONE;
            end else begin
               r_cnt <= {1'b0, r_per};
               r_vol <= w_vol_step;
               if (w_at_lim) r_state <= ST_HOLD;
            end
         end
      end
   end

   assign target_vol = r_vol;
   assign dac_enable = r_dac_en;
   assign env_done   = (r_state == ST_HOLD);

endmodule

// File: tb/tb_sound_vol_env.sv
// Directed self-checking bench for sound_vol_env; also covers VOL_ENV_PRESCALE_EN when defined.
module tb_sound_vol_env;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       env_tick;
   logic       trigger;
   logic [3:0] init_vol;
   logic       env_dir;
   logic [2:0] env_period;
   logic [3:0] target_vol;
   logic       dac_enable;
   logic       env_done;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_seq [6] = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};

   sound_vol_env #(.PERIOD_W(3), .VOL_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .env_tick   (env_tick),
      .trigger    (trigger),
      .init_vol   (init_vol),
      .env_dir    (env_dir),
      .env_period (env_period),
      .target_vol (target_vol),
      .dac_enable (dac_enable),
      .env_done   (env_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      env_tick = 1'b1;
      step();
      env_tick = 1'b0;
   endtask

   // One envelope tick as seen by the stepping logic.
   task automatic env_step();
`ifdef VOL_ENV_PRESCALE_EN
      repeat (8) pulse_tick();
`else
      pulse_tick();
`endif
   endtask

   task automatic set_reg(input logic [3:0] v, input logic d, input logic [2:0] p);
      init_vol   = v;
      env_dir    = d;
      env_period = p;
      step();
   endtask

   task automatic do_trigger();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; env_tick = 1'b0; trigger = 1'b0;
      init_vol = 4'd0; env_dir = 1'b0; env_period = 3'd0;
      repeat (3) step();
      check("rst_vol",  8'(target_vol), 8'h0);
      check("rst_dac",  8'(dac_enable), 8'h0);
      check("rst_done", 8'(env_done),   8'h0);
      rst_n = 1'b1;
      step();

      // Frozen envelope: period 0 goes straight to HOLD.
      set_reg(4'hA, 1'b0, 3'd0);
      check("t1_dac", 8'(dac_enable), 8'h1);
      do_trigger();
      check("t1_vol",  8'(target_vol), 8'hA);
      check("t1_done", 8'(env_done),   8'h1);
      repeat (10) env_step();
      check("t1_vol_after_ticks", 8'(target_vol), 8'hA);

      // Decrease from 3, period 2.
      set_reg(4'h3, 1'b0, 3'd2);
      do_trigger();
      check("t2_vol0",  8'(target_vol), 8'h3);
      check("t2_done0", 8'(env_done),   8'h0);
      for (int i = 0; i < 6; i++) begin
         env_step();
         check($sformatf("t2_vol_tick%0d", i + 1), 8'(target_vol), 8'(exp_seq[i]));
      end
      check("t2_done", 8'(env_done), 8'h1);
      repeat (3) env_step();
      check("t2_no_wrap", 8'(target_vol), 8'h0);

      // Increase to the top limit.
      set_reg(4'hE, 1'b1, 3'd1);
      do_trigger();
      check("t3_vol0",  8'(target_vol), 8'hE);
      check("t3_done0", 8'(env_done),   8'h0);
      env_step();
      check("t3_vol",  8'(target_vol), 8'hF);
      check("t3_done", 8'(env_done),   8'h1);
      set_reg(4'hF, 1'b1, 3'd3);
      do_trigger();
      check("t3_full_vol",  8'(target_vol), 8'hF);
      check("t3_full_done", 8'(env_done),   8'h1);

      // Trigger and tick together: trigger wins, counter reloaded.
      set_reg(4'h5, 1'b0, 3'd1);
      do_trigger();
      check("t4_vol0", 8'(target_vol), 8'h5);
`ifdef VOL_ENV_PRESCALE_EN
      repeat (7) pulse_tick();
      check("t4_pre_vol", 8'(target_vol), 8'h5);
`endif
      init_vol = 4'h9;
      trigger  = 1'b1;
      env_tick = 1'b1;
      step();
      trigger  = 1'b0;
      env_tick = 1'b0;
      check("t4_vol",  8'(target_vol), 8'h9);
      check("t4_done", 8'(env_done),   8'h0);
      env_step();
      check("t4_vol_step", 8'(target_vol), 8'h8);

      // DAC off mid-run.
      init_vol = 4'h0;
      env_dir  = 1'b0;
      step();
      check("t5_dac", 8'(dac_enable), 8'h0);
      step();
      check("t5_vol",  8'(target_vol), 8'h0);
      check("t5_done", 8'(env_done),   8'h0);
      do_trigger();
      check("t5_ign_vol",  8'(target_vol), 8'h0);
      check("t5_ign_done", 8'(env_done),   8'h0);
      env_step();
      check("t5_ign_tick", 8'(target_vol), 8'h0);
      set_reg(4'h0, 1'b1, 3'd1);
      check("t5_dac_on", 8'(dac_enable), 8'h1);
      do_trigger();
      check("t5_run_vol",  8'(target_vol), 8'h0);
      check("t5_run_done", 8'(env_done),   8'h0);
      env_step();
      check("t5_run_step", 8'(target_vol), 8'h1);

`ifdef VOL_ENV_PRESCALE_EN
      // Steps land on the 8th and 16th raw pulses.
      set_reg(4'h4, 1'b0, 3'd1);
      do_trigger();
      for (int i = 1; i <= 16; i++) begin
         pulse_tick();
         if (i == 7)  check("t6_p7",  8'(target_vol), 8'h4);
         if (i == 8)  check("t6_p8",  8'(target_vol), 8'h3);
         if (i == 15) check("t6_p15", 8'(target_vol), 8'h3);
         if (i == 16) check("t6_p16", 8'(target_vol), 8'h2);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sound_vol_env.md
Name: sound_vol_env

Overview:
- Volume envelope generator for one pulse or noise channel.
- Sits directly upstream of the channel mixer. Its target_vol feeds the mixer's target_vol input, and its dac_enable is one term of the mixer's enable.
- Implements NRx2 semantics: initial volume, direction and step period, advanced by the frame-sequencer envelope tick and restarted by channel trigger.

Parameters:
- PERIOD_W, 3, width of the envelope step-period field; the reload value for a zero period is 2**PERIOD_W.
- VOL_W, 4, width of the volume output.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- env_tick  input  1  one-cycle envelope clock pulse (64 Hz), or the 512 Hz frame-sequencer pulse when VOL_ENV_PRESCALE_EN is defined.
- trigger  input  1  one-cycle channel restart pulse (NRx4 bit 7 write).
- init_vol  input  VOL_W  NRx2[7:4], live register value.
- env_dir  input  1  NRx2[3]; 1 = increase, 0 = decrease.
- env_period  input  PERIOD_W  NRx2[2:0]; 0 = envelope frozen.
- target_vol  output  VOL_W  current envelope volume, to the mixer.
- dac_enable  output  1  channel DAC power, registered.
- env_done  output  1  envelope has stopped stepping (HOLD state).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: target_vol=0, dac_enable=0, env_done=0, state=IDLE, step counter=0, latched direction/period=0, prescaler=0.
- dac_enable is registered every cycle as OR(init_vol, env_dir), so it follows NRx2 with 1-cycle latency.
- DAC off: while dac_enable=0, state is forced to IDLE and target_vol to 0. A trigger in this condition is ignored.
- States:
  - IDLE: no trigger since reset or DAC-off; env_done=0.
  - RUN: envelope stepping.
  - HOLD: volume frozen; env_done=1.
- Trigger (with dac_enable=1), in the next cycle:
  - target_vol <= init_vol.
  - dir_l <= env_dir, per_l <= env_period.
  - cnt <= env_period, or 2**PERIOD_W if env_period=0.
  - Next state is HOLD if env_period=0, or if env_dir=1 and init_vol=all ones, or if env_dir=0 and init_vol=0. Otherwise next state is RUN.
- Trigger from any state, including mid-run and HOLD, fully restarts the envelope.
- Tick in RUN, no trigger:
  - If cnt>1: cnt <= cnt-1.
  - If cnt==1: cnt <= per_l, and target_vol steps by +1 (dir_l=1) or -1 (dir_l=0).
  - If the stepped value equals the limit (all ones when increasing, 0 when decreasing), next state is HOLD.
  - Volume never wraps.
- Ticks in IDLE or HOLD are ignored.
- Trigger and tick in the same cycle: trigger wins and the tick is dropped.
- NRx2 changes while in RUN: they affect only dac_enable. The latched dir_l/per_l remain in effect until the next trigger.
- Latency: trigger -> target_vol valid is 1 cycle. Step tick -> new target_vol is 1 cycle.

Optional Feature:
- Macro: VOL_ENV_PRESCALE_EN.
- Defined:
  - env_tick is the 512 Hz frame-sequencer pulse.
  - An internal 3-bit prescaler counts env_tick pulses and issues an internal envelope tick on every 8th pulse (prescaler wrapping 7->0), i.e. 64 Hz.
  - The prescaler is reset by rst_n only, not by trigger.
  - Ticks arriving while state is IDLE still advance the prescaler.
- Undefined:
  - env_tick is used directly as the envelope tick.
  - No prescaler register exists.

Test Plan:
- Reset release, init_vol=0xA, env_dir=0, env_period=0, trigger -> dac_enable=1 and target_vol=0xA one cycle later. State is HOLD, env_done=1. Ten ticks leave target_vol=0xA.
- init_vol=0x3, env_dir=0, env_period=2, trigger, then 6 ticks -> target_vol takes 3,3,2,2,1,1,0. env_done=1 after the 6th tick. Further ticks keep 0, with no wrap to 0xF.
- init_vol=0xE, env_dir=1, env_period=1, trigger, 1 tick -> target_vol=0xF and env_done=1. A trigger with init_vol=0xF, env_dir=1 -> HOLD immediately.
- RUN at volume 0x5 with cnt=1: assert trigger and tick in the same cycle with init_vol=0x9 -> target_vol=0x9 with no step applied, and cnt reloaded.
- Mid-run, write init_vol=0, env_dir=0 -> dac_enable=0 one cycle later, then target_vol=0 and IDLE. A subsequent trigger is ignored until NRx2 becomes nonzero.
- With VOL_ENV_PRESCALE_EN defined: env_period=1, decrease from 0x4, 16 env_tick pulses -> target_vol=0x2, with steps occurring on the 8th and 16th pulses.
